// File: rtl/rc4_pass_scheduler_if.sv
// Handshake and S-RAM port bundle for the RC4 pass scheduler.
// The master side is the surrounding system: the key-search loop that
// issues start/abort, plus the three S-memory engines and the RAM.
// The slave side is the scheduler itself.
interface rc4_pass_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  // Key-search loop handshake
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic                  error;
  logic [1:0]            phase;
  logic [15:0]           pass_count;

  // Engine start/done handshakes
  logic                  init_start;
  logic                  shuf_start;
  logic                  dec_start;
  logic                  init_done;
  logic                  shuf_done;
  logic                  dec_done;

  // Engine-side S-RAM requests
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [ADDR_WIDTH-1:0] shuf_addr;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [DATA_WIDTH-1:0] init_data;
  logic [DATA_WIDTH-1:0] shuf_data;
  logic                  init_wren;
  logic                  shuf_wren;

  // Shared S-RAM port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;

  modport master (
    output start, abort,
    output init_done, shuf_done, dec_done,
    output init_addr, shuf_addr, dec_addr,
    output init_data, shuf_data, init_wren, shuf_wren,
    input  busy, done, aborted, error, phase, pass_count,
    input  init_start, shuf_start, dec_start,
    input  mem_addr, mem_data, mem_wren
  );

  modport slave (
    input  start, abort,
    input  init_done, shuf_done, dec_done,
    input  init_addr, shuf_addr, dec_addr,
    input  init_data, shuf_data, init_wren, shuf_wren,
    output busy, done, aborted, error, phase, pass_count,
    output init_start, shuf_start, dec_start,
    output mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/rc4_pass_scheduler.sv
// Top-level sequencer for one RC4 key trial: runs S init, key-schedule
// shuffle and decrypt in order, owns the single S-RAM port on behalf of
// whichever engine is running, and guards every engine wait with a
// timeout that parks the block in a sticky ERROR state.
module rc4_pass_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096   // legal range 2..65535
) (
  input logic                 clk,
  input logic                 reset,    // synchronous, active low
  rc4_pass_scheduler_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    SHUF_GO,
    SHUF_WAIT,
    DEC_GO,
    DEC_WAIT,
    FINISH,
    ERROR
  } state_t;

  // Phase codes double as the port-owner select for the RAM mux.
  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_SHUF = 2'd2;
  localparam logic [1:0] PH_DEC  = 2'd3;

  // Last wait-counter value an engine may still answer on.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [15:0]           wait_cnt;
  logic [15:0]           pass_count_q;
  logic                  error_q;
  logic                  aborted_q;

  logic                  busy_w;
  logic [1:0]            phase_w;
  logic                  timeout_hit;

  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0] mux_data;
  logic                  mux_wren;

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // Decode busy and port owner from the registered state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which is what keeps a latch from appearing.
    busy_w  = 1'b1;
    phase_w = PH_NONE;
    unique case (state)
      IDLE, ERROR:          busy_w  = 1'b0;
      INIT_GO, INIT_WAIT:   phase_w = PH_INIT;
      SHUF_GO, SHUF_WAIT:   phase_w = PH_SHUF;
      DEC_GO, DEC_WAIT:     phase_w = PH_DEC;
      default:              phase_w = PH_NONE;
    endcase
  end

  // Pass sequencer: state, wait timer, sticky error, abort pulse, pass count.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every branch
    // reads the values from before this edge, independent of statement order.
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      pass_count_q <= '0;
      error_q      <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      if (busy_w && bus.abort) begin
        // Abort outranks a same-cycle engine done and a timeout.
        state     <= IDLE;
        aborted_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= INIT_GO;
              wait_cnt <= '0;
            end
          end

          ERROR: begin
            if (bus.start) begin
              state    <= INIT_GO;
              wait_cnt <= '0;
              error_q  <= 1'b0;
            end
          end

          INIT_GO: state <= INIT_WAIT;

          INIT_WAIT: begin
            if (bus.init_done) begin
              state    <= SHUF_GO;
              wait_cnt <= '0;
            end else if (timeout_hit) begin
              state   <= ERROR;
              error_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end

          SHUF_GO: state <= SHUF_WAIT;

          SHUF_WAIT: begin
            if (bus.shuf_done) begin
              state    <= DEC_GO;
              wait_cnt <= '0;
            end else if (timeout_hit) begin
              state   <= ERROR;
              error_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end

          DEC_GO: state <= DEC_WAIT;

          DEC_WAIT: begin
            if (bus.dec_done) begin
              state <= FINISH;
            end else if (timeout_hit) begin
              state   <= ERROR;
              error_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end

          FINISH: begin
            state <= IDLE;
            if (pass_count_q != 16'hFFFF) begin
              pass_count_q <= pass_count_q + 16'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // S-RAM port mux: only the current owner reaches the port; decrypt is read-only.
  always_comb begin
    mux_addr = '0;
    mux_data = '0;
    mux_wren = 1'b0;
    unique case (phase_w)
      PH_INIT: begin
        mux_addr = bus.init_addr;
        mux_data = bus.init_data;
        mux_wren = bus.init_wren;
      end
      PH_SHUF: begin
        mux_addr = bus.shuf_addr;
        mux_data = bus.shuf_data;
        mux_wren = bus.shuf_wren;
      end
      PH_DEC: begin
        mux_addr = bus.dec_addr;
      end
      default: begin
        mux_addr = '0;
      end
    endcase
  end

  assign bus.mem_addr   = mux_addr;
  assign bus.mem_data   = mux_data;
  assign bus.mem_wren   = mux_wren;

  assign bus.busy       = busy_w;
  assign bus.phase      = phase_w;
  assign bus.done       = (state == FINISH);
  assign bus.aborted    = aborted_q;
  assign bus.error      = error_q;
  assign bus.pass_count = pass_count_q;

  assign bus.init_start = (state == INIT_GO);
  assign bus.shuf_start = (state == SHUF_GO);
  assign bus.dec_start  = (state == DEC_GO);

endmodule

// File: tb/tb_rc4_pass_scheduler.sv
// Bench for rc4_pass_scheduler. Each segment is one pass planned as a
// timeline: engine response delays, optional abort or reset, then the
// expected per-cycle waveform derived from the pass timing rules.
module tb_rc4_pass_scheduler;

  localparam int T   = 8;    // TIMEOUT_CYCLES used for the DUT
  localparam int SEG = 40;   // longest planned segment, in cycles

  logic clk;
  logic reset;

  rc4_pass_scheduler_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_if ();

  rc4_pass_scheduler #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_mis;
  int gcyc;

  // Planned stimulus for one segment
  bit st_start [SEG];
  bit st_abort [SEG];
  bit st_rst   [SEG];
  bit st_done  [3][SEG];
  int own_wait [SEG];

  // Expected waveform for one segment
  int ex_phase [SEG];
  bit ex_busy  [SEG];
  bit ex_fin   [SEG];
  bit ex_abrt  [SEG];
  bit ex_err   [SEG];
  bit ex_go    [3][SEG];
  int ex_pc    [SEG];

  // Model state carried between segments
  int pc_model;
  bit err_model;
  int pc_after;
  bit err_after;
  int base_last;
  bit completed;
  int seg_len;
  bit fixed_bus;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, gcyc, act, exp);
    end
  endtask

  // Lay out one pass starting with start high in cycle 0.
  task automatic plan_base(input int d0, input int d1, input int d2);
    int dl [3];
    int t;
    dl[0] = d0;
    dl[1] = d1;
    dl[2] = d2;
    for (int c = 0; c < SEG; c++) begin
      st_start[c] = 1'b0;
      st_abort[c] = 1'b0;
      st_rst[c]   = 1'b0;
      own_wait[c] = 0;
      ex_phase[c] = 0;
      ex_busy[c]  = 1'b0;
      ex_fin[c]   = 1'b0;
      ex_abrt[c]  = 1'b0;
      ex_err[c]   = (c == 0) ? err_model : 1'b0;
      ex_pc[c]    = pc_model;
      for (int p = 0; p < 3; p++) begin
        st_done[p][c] = 1'b0;
        ex_go[p][c]   = 1'b0;
      end
    end
    st_start[0] = 1'b1;
    t           = 1;
    completed   = 1'b1;
    pc_after    = pc_model;
    err_after   = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (completed) begin
        ex_phase[t] = p + 1;
        ex_busy[t]  = 1'b1;
        ex_go[p][t] = 1'b1;
        t++;
        if (dl[p] < T) begin
          // engine answers on wait cycle dl[p]
          for (int w = 0; w <= dl[p]; w++) begin
            ex_phase[t+w] = p + 1;
            ex_busy[t+w]  = 1'b1;
            own_wait[t+w] = p + 1;
          end
          st_done[p][t+dl[p]] = 1'b1;
          t += dl[p] + 1;
        end else begin
          // engine never answers: T wait cycles, then ERROR
          for (int w = 0; w < T; w++) begin
            ex_phase[t+w] = p + 1;
            ex_busy[t+w]  = 1'b1;
            own_wait[t+w] = p + 1;
          end
          t += T;
          for (int c = t; c < SEG; c++) ex_err[c] = 1'b1;
          completed = 1'b0;
          err_after = 1'b1;
        end
      end
    end
    if (completed) begin
      ex_busy[t] = 1'b1;
      ex_fin[t]  = 1'b1;
      pc_after   = (pc_model == 65535) ? 65535 : pc_model + 1;
      for (int c = t + 1; c < SEG; c++) ex_pc[c] = pc_after;
    end
    base_last = t;
  endtask

  task automatic wipe_after(input int x, input int pc);
    for (int c = x + 1; c < SEG; c++) begin
      ex_phase[c] = 0;
      ex_busy[c]  = 1'b0;
      ex_fin[c]   = 1'b0;
      ex_abrt[c]  = 1'b0;
      ex_err[c]   = 1'b0;
      ex_pc[c]    = pc;
      own_wait[c] = 0;
      for (int p = 0; p < 3; p++) ex_go[p][c] = 1'b0;
    end
  endtask

  task automatic apply_abort(input int a);
    st_abort[a] = 1'b1;
    wipe_after(a, pc_model);
    ex_abrt[a+1] = 1'b1;
    base_last    = a + 1;
    completed    = 1'b0;
    pc_after     = pc_model;
    err_after    = 1'b0;
  endtask

  task automatic apply_rst(input int r);
    st_rst[r]   = 1'b1;
    st_start[r] = 1'b1;
    wipe_after(r, 0);
    base_last = r + 1;
    completed = 1'b0;
    pc_after  = 0;
    err_after = 1'b0;
  endtask

  // Segment length, back-to-back hand-off and ignorable noise.
  task automatic finalize(input bit b2b, input bit noise);
    if (b2b && completed) begin
      seg_len             = base_last + 1;
      st_start[base_last] = 1'b1;
    end else begin
      seg_len = base_last + 1 + int'($urandom_range(1, 3));
    end
    if (noise) begin
      for (int c = 0; c < seg_len; c++) begin
        if (ex_busy[c] && !st_rst[c]) st_start[c] |= 1'($urandom);
        if (!ex_busy[c] && !st_rst[c]) st_abort[c] |= ($urandom_range(0, 3) == 0);
        for (int p = 0; p < 3; p++) begin
          if (own_wait[c] != p + 1) st_done[p][c] |= ($urandom_range(0, 3) == 0);
        end
      end
    end
  endtask

  task automatic drive_bus();
    if (fixed_bus) begin
      bus_if.init_addr = 8'h11;
      bus_if.init_data = 8'hC3;
      bus_if.init_wren = 1'b1;
      bus_if.shuf_addr = 8'h80;
      bus_if.shuf_data = 8'h5A;
      bus_if.shuf_wren = 1'b1;
      bus_if.dec_addr  = 8'h33;
    end else begin
      bus_if.init_addr = 8'($urandom);
      bus_if.init_data = 8'($urandom);
      bus_if.init_wren = 1'($urandom);
      bus_if.shuf_addr = 8'($urandom);
      bus_if.shuf_data = 8'($urandom);
      bus_if.shuf_wren = 1'($urandom);
      bus_if.dec_addr  = 8'($urandom);
    end
  endtask

  task automatic run_seg();
    logic [7:0] e_addr;
    logic [7:0] e_data;
    logic       e_wren;
    for (int c = 0; c < seg_len; c++) begin
      reset            = ~st_rst[c];
      bus_if.start     = st_start[c];
      bus_if.abort     = st_abort[c];
      bus_if.init_done = st_done[0][c];
      bus_if.shuf_done = st_done[1][c];
      bus_if.dec_done  = st_done[2][c];
      drive_bus();
      case (ex_phase[c])
        1:       begin e_addr = bus_if.init_addr; e_data = bus_if.init_data; e_wren = bus_if.init_wren; end
        2:       begin e_addr = bus_if.shuf_addr; e_data = bus_if.shuf_data; e_wren = bus_if.shuf_wren; end
        3:       begin e_addr = bus_if.dec_addr;  e_data = 8'h00;            e_wren = 1'b0;             end
        default: begin e_addr = 8'h00;            e_data = 8'h00;            e_wren = 1'b0;             end
      endcase
      @(negedge clk);
      check("phase",      32'(bus_if.phase),      32'(ex_phase[c]));
      check("busy",       32'(bus_if.busy),       32'(ex_busy[c]));
      check("done",       32'(bus_if.done),       32'(ex_fin[c]));
      check("aborted",    32'(bus_if.aborted),    32'(ex_abrt[c]));
      check("error",      32'(bus_if.error),      32'(ex_err[c]));
      check("pass_count", 32'(bus_if.pass_count), 32'(ex_pc[c]));
      check("init_start", 32'(bus_if.init_start), 32'(ex_go[0][c]));
      check("shuf_start", 32'(bus_if.shuf_start), 32'(ex_go[1][c]));
      check("dec_start",  32'(bus_if.dec_start),  32'(ex_go[2][c]));
      check("mem_addr",   32'(bus_if.mem_addr),   32'(e_addr));
      check("mem_data",   32'(bus_if.mem_data),   32'(e_data));
      check("mem_wren",   32'(bus_if.mem_wren),   32'(e_wren));
      @(posedge clk);
      #1;
      gcyc++;
    end
    pc_model  = pc_after;
    err_model = err_after;
  endtask

  initial begin
    int d0, d1, d2, sel;
    n_cmp     = 0;
    n_mis     = 0;
    gcyc      = 0;
    pc_model  = 0;
    err_model = 1'b0;
    fixed_bus = 1'b0;
    reset            = 1'b0;
    bus_if.start     = 1'b1;
    bus_if.abort     = 1'b0;
    bus_if.init_done = 1'b1;
    bus_if.shuf_done = 1'b1;
    bus_if.dec_done  = 1'b1;
    drive_bus();

    // Reset state: everything zero even with start and dones asserted.
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      drive_bus();
      @(negedge clk);
      check("rst_phase",      32'(bus_if.phase),      32'd0);
      check("rst_busy",       32'(bus_if.busy),       32'd0);
      check("rst_done",       32'(bus_if.done),       32'd0);
      check("rst_error",      32'(bus_if.error),      32'd0);
      check("rst_pass_count", 32'(bus_if.pass_count), 32'd0);
      check("rst_init_start", 32'(bus_if.init_start), 32'd0);
      check("rst_mem_addr",   32'(bus_if.mem_addr),   32'd0);
      check("rst_mem_wren",   32'(bus_if.mem_wren),   32'd0);
      @(posedge clk);
      #1;
      gcyc++;
    end
    reset = 1'b1;

    // Nominal pass: dones at cycles 4, 9, 15; done pulse at 16.
    fixed_bus = 1'b1;
    plan_base(2, 3, 4);
    finalize(1'b0, 1'b0);
    run_seg();
    fixed_bus = 1'b0;

    // Back-to-back passes with start held; spurious dec_done in INIT_WAIT.
    plan_base(1, 1, 1);
    st_done[2][3] = 1'b1;
    finalize(1'b1, 1'b0);
    run_seg();
    plan_base(0, 0, 0);
    finalize(1'b0, 1'b0);
    run_seg();

    // Abort in SHUF_WAIT in the same cycle as shuf_done.
    plan_base(0, 3, 2);
    apply_abort(7);
    finalize(1'b0, 1'b0);
    run_seg();

    // Timeout in INIT_WAIT; ERROR must hold until the next start.
    plan_base(T, 0, 0);
    finalize(1'b0, 1'b0);
    run_seg();

    // Start out of ERROR, then reset during DEC_WAIT with pass_count 3.
    plan_base(1, 1, 5);
    apply_rst(10);
    finalize(1'b0, 1'b0);
    run_seg();

    // Randomized passes.
    for (int n = 0; n < 250; n++) begin
      d0 = ($urandom_range(0, 7) == 0) ? T + int'($urandom_range(0, 1)) : int'($urandom_range(0, T - 1));
      d1 = ($urandom_range(0, 7) == 0) ? T + int'($urandom_range(0, 1)) : int'($urandom_range(0, T - 1));
      d2 = ($urandom_range(0, 7) == 0) ? T + int'($urandom_range(0, 1)) : int'($urandom_range(0, T - 1));
      plan_base(d0, d1, d2);
      sel = int'($urandom_range(0, 19));
      if (sel < 4) begin
        apply_abort(int'($urandom_range(1, base_last - 1)));
      end else if (sel == 4) begin
        apply_rst(int'($urandom_range(1, base_last - 1)));
      end
      finalize(1'($urandom), 1'b1);
      run_seg();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rc4_pass_scheduler.md
Name: rc4_pass_scheduler

Overview:
- Top-level sequencer for one RC4 key trial.
- Runs the three S-memory engines in fixed order: S init (S[i]=i), key schedule shuffle, then decryption. Uses start/done handshakes.
- Arbitrates the single S-RAM port so that only the engine currently running drives address, data and write enable.
- Sits between the key-search loop, which issues start and consumes done/error, and the shared 256x8 S memory.

Parameters:
- DATA_WIDTH, 8, S word width.
- ADDR_WIDTH, 8, S address width.
- TIMEOUT_CYCLES, 4096, max cycles allowed in any engine WAIT state; valid range 2..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- start  input  1  request a pass; sampled only in IDLE or ERROR.
- abort  input  1  cancel the pass in progress.
- busy  output  1  high in every state except IDLE and ERROR.
- done  output  1  one-cycle pulse when a pass completes.
- aborted  output  1  one-cycle pulse when abort is taken.
- error  output  1  sticky timeout flag.
- phase  output  2  current port owner: 0 none, 1 init, 2 shuffle, 3 decrypt.
- pass_count  output  16  completed passes, saturating at 0xFFFF.
- init_start, shuf_start, dec_start  output  1 each  one-cycle engine start pulses.
- init_done, shuf_done, dec_done  input  1 each  engine completion.
- init_addr, shuf_addr, dec_addr  input  ADDR_WIDTH each  engine addresses.
- init_data, shuf_data  input  DATA_WIDTH each  engine write data.
- init_wren, shuf_wren  input  1 each  engine write enables.
- mem_addr  output  ADDR_WIDTH  to S RAM.
- mem_data  output  DATA_WIDTH  to S RAM.
- mem_wren  output  1  to S RAM.

Behaviour:
- States: IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, FINISH, ERROR.
- Reset (reset==0 at an edge):
  - state goes to IDLE.
  - All outputs are 0, including pass_count, error and phase.
  - Reset wins over every other input.
- Transitions:
  - IDLE, start=1: INIT_GO.
  - X_GO: X_WAIT unconditionally.
  - INIT_WAIT, init_done=1: SHUF_GO.
  - SHUF_WAIT, shuf_done=1: DEC_GO.
  - DEC_WAIT, dec_done=1: FINISH.
  - FINISH: IDLE.
  - ERROR, start=1: INIT_GO, and error clears.
- Start pulses:
  - X_start is high only during the X_GO cycle, decoded from the registered state.
  - X_done is ignored during X_GO and in every state not owned by X.
- Port ownership:
  - phase=1 in INIT_GO and INIT_WAIT; 2 in SHUF_GO and SHUF_WAIT; 3 in DEC_GO and DEC_WAIT; 0 otherwise.
  - The mem mux is combinational from phase.
    - phase 1 or 2: mem_addr, mem_data and mem_wren come from the owner.
    - phase 3: mem_addr=dec_addr, mem_data=0, mem_wren=0, because decrypt never writes S.
    - phase 0: all mem outputs are 0.
  - Non-owner inputs never reach the port.
- Minimum latency, with every done returned at the earliest cycle:
  - start sampled at edge k gives init_start in cycle k+1.
  - done is high in cycle k+7.
- FINISH:
  - done=1 for that single cycle.
  - pass_count increments at the edge leaving FINISH, unless it is already 0xFFFF.
- start:
  - Ignored while busy.
  - start held high through FINISH begins a new pass on the first IDLE cycle, so passes run back to back with one IDLE cycle between them.
- abort:
  - Taken in any state other than IDLE or ERROR; the next state is IDLE.
  - aborted=1 for the following cycle.
  - No done pulse and no pass_count change.
  - abort has priority over a simultaneous X_done or a timeout.
  - abort in IDLE or ERROR is ignored.
- Timeout:
  - A 16-bit wait counter clears on entry to each X_GO and increments in X_WAIT.
  - If the counter equals TIMEOUT_CYCLES-1 and X_done=0, the next state is ERROR and error=1.
  - X_done=1 in that same cycle takes precedence, so no error is raised.
  - In ERROR: phase=0 and busy=0; error stays high until reset or start.

Test Plan:
- Nominal pass:
  - Stimulus: start pulse at cycle 0; init_done at cycle 4, shuf_done at cycle 9, dec_done at cycle 15.
  - Required: one-cycle pulses init_start@1, shuf_start@5, dec_start@10, done@16; pass_count=1.
  - Required: phase sequence 1,2,3,0.
- Port mux:
  - Stimulus: during shuffle, init_wren=1, init_addr=0x11, shuf_wren=1, shuf_addr=0x80, shuf_data=0x5A.
  - Required: mem = 0x80/0x5A/1.
  - Stimulus: during decrypt, dec_addr=0x33.
  - Required: mem_addr=0x33, mem_wren=0.
- Abort:
  - Stimulus: abort in SHUF_WAIT in the same cycle as shuf_done=1.
  - Required: next state IDLE, aborted pulse, no dec_start, no done, pass_count unchanged, mem_wren=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; init_done never asserted.
  - Required: error=1 exactly 8 cycles after INIT_WAIT entry; busy=0; start is then accepted and error clears.
- Reset mid-pass:
  - Stimulus: reset=0 for one cycle during DEC_WAIT, with pass_count=3.
  - Required: all outputs 0, pass_count=0, IDLE; start in the same cycle as reset is ignored.
- Back-to-back and ignored events:
  - Stimulus: start held high across 2 passes; spurious dec_done during INIT_WAIT.
  - Required: second init_start 2 cycles after the first done; spurious done ignored; pass_count=2.
